// File: rtl/brisc_pkg.sv
// Shared integer-core definitions: register file geometry, write-back request
// record and write-back source identifiers.
package brisc_pkg;

  localparam int REG_BITS = 5;
  localparam int REG_NUM  = 32;
  localparam int REG_LEN  = 32;

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic [REG_LEN-1:0]  data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MUL = 2'd1,
    WB_MEM = 2'd2
  } wb_src_e;

  // Round-robin successor: ALU -> MUL -> MEM -> ALU.
  function automatic wb_src_e next_src(input wb_src_e s);
    case (s)
      WB_ALU:  return WB_MUL;
      WB_MUL:  return WB_MEM;
      default: return WB_ALU;
    endcase
  endfunction

  // One-hot decode of a register index.
  function automatic logic [REG_NUM-1:0] rd_onehot(input logic [REG_BITS-1:0] rd);
    logic [REG_NUM-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source write-back result FIFO. All entries and their valid flags are
// exposed so the owner can build the pending-register mask.
module wb_fifo
  import brisc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output wb_req_t               head,
  output logic [DEPTH-1:0]      entry_valid,
  output wb_req_t [DEPTH-1:0]   entries
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  wb_req_t [DEPTH-1:0]  mem;
  logic                 push_ok;
  logic                 pop_ok;

  // A push into a full FIFO is refused even if a pop happens the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by entry_valid, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_req;
  end

  assign full    = count[AW];
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // An entry is live when its distance from the read pointer is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [AW-1:0] offset;
    assign offset          = AW'(gi) - rd_ptr;
    assign entry_valid[gi] = ({1'b0, offset} < count);
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register file write-back arbiter: buffers ALU/MUL/MEM results, serialises
// them round-robin onto the single write port and exports a pending mask.
module rf_wb_arbiter
  import brisc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [REG_BITS-1:0] alu_rd,
  input  logic [REG_LEN-1:0]  alu_data,
  input  logic                mul_valid,
  output logic                mul_ready,
  input  logic [REG_BITS-1:0] mul_rd,
  input  logic [REG_LEN-1:0]  mul_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [REG_BITS-1:0] mem_rd,
  input  logic [REG_LEN-1:0]  mem_data,
  output logic                rf_we,
  output logic [REG_BITS-1:0] rf_waddr,
  output logic [REG_LEN-1:0]  rf_wdata,
  output logic [REG_NUM-1:0]  pending
);

  localparam int NSRC = 3;

  logic [NSRC-1:0]     src_valid;
  logic [NSRC-1:0]     src_full;
  logic [NSRC-1:0]     src_empty;
  logic [NSRC-1:0]     src_push;
  logic [NSRC-1:0]     src_pop;
  wb_req_t             src_req [NSRC];
  wb_req_t             src_head [NSRC];
  logic [DEPTH-1:0]    src_entry_valid [NSRC];
  wb_req_t [DEPTH-1:0] src_entries [NSRC];

  wb_src_e rr_start;
  wb_src_e grant_src;
  wb_src_e cand;
  logic    grant;
  wb_req_t win;

  assign src_valid  = {mem_valid, mul_valid, alu_valid};
  assign src_req[0] = '{rd: alu_rd, data: alu_data};
  assign src_req[1] = '{rd: mul_rd, data: mul_data};
  assign src_req[2] = '{rd: mem_rd, data: mem_data};

  // Ready is purely the registered full flag.
  assign alu_ready = !src_full[0];
  assign mul_ready = !src_full[1];
  assign mem_ready = !src_full[2];

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign src_push[gi] = src_valid[gi] && !src_full[gi];

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (src_push[gi]),
      .push_req    (src_req[gi]),
      .pop         (src_pop[gi]),
      .full        (src_full[gi]),
      .empty       (src_empty[gi]),
      .head        (src_head[gi]),
      .entry_valid (src_entry_valid[gi]),
      .entries     (src_entries[gi])
    );
  end

  // Round-robin pick of the first non-empty source starting at rr_start.
  always_comb begin
    grant     = 1'b0;
    grant_src = rr_start;
    cand      = rr_start;
    src_pop   = '0;
    for (int off = 0; off < NSRC; off++) begin
      if (!grant && !src_empty[cand]) begin
        grant     = 1'b1;
        grant_src = cand;
      end
      cand = next_src(cand);
    end
    if (grant) src_pop[grant_src] = 1'b1;
  end

  assign win = src_head[grant_src];

  // Output register and round-robin pointer; rd==0 consumes a slot silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_start <= WB_ALU;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant) begin
      rr_start <= next_src(grant_src);
      rf_we    <= (win.rd != '0);
      rf_waddr <= win.rd;
      rf_wdata <= win.data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Pending mask: every buffered destination plus the one on the port.
  always_comb begin
    pending = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (src_entry_valid[s][e]) pending = pending | rd_onehot(src_entries[s][e].rd);
      end
    end
    if (rf_we) pending = pending | rd_onehot(rf_waddr);
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_rf_wb_arbiter;
  import brisc_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mul_valid, mem_valid;
  logic        alu_ready, mul_ready, mem_ready;
  logic [4:0]  alu_rd, mul_rd, mem_rd;
  logic [31:0] alu_data, mul_data, mem_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rd(mul_rd), .mul_data(mul_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per source plus the write-port register.
  wb_req_t     q [3][$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_start;
  int          writes_seen = 0;
  logic [4:0]  wr_log [$];

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  r0, r1, r2;
    logic [31:0] d0, d1, d2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pend;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) q[s].delete();
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_start = 0;
  endtask

  // One clock of traffic: drive, advance model across the edge, compare.
  task automatic step(input logic [2:0] v, input logic [4:0] r0, r1, r2,
                      input logic [31:0] d0, d1, d2, output logic [2:0] acc);
    wb_req_t     inr [3];
    wb_req_t     e;
    int          g;
    logic [31:0] pend;
    inr[0] = '{rd: r0, data: d0};
    inr[1] = '{rd: r1, data: d1};
    inr[2] = '{rd: r2, data: d2};
    alu_valid = v[0]; alu_rd = r0; alu_data = d0;
    mul_valid = v[1]; mul_rd = r1; mul_data = d1;
    mem_valid = v[2]; mem_rd = r2; mem_data = d2;
    for (int s = 0; s < 3; s++) acc[s] = v[s] && (q[s].size() < DEPTH);
    @(posedge clk);
    g = -1;
    for (int o = 0; o < 3; o++)
      if (g < 0 && q[(m_start + o) % 3].size() > 0) g = (m_start + o) % 3;
    if (g >= 0) begin
      e = q[g].pop_front();
      m_we = (e.rd != 0); m_waddr = e.rd; m_wdata = e.data;
      m_start = (g + 1) % 3;
    end else begin
      m_we = 1'b0;
    end
    for (int s = 0; s < 3; s++) begin
      if (acc[s]) begin
        for (int t = 0; t < 3; t++)
          for (int i = 0; i < q[t].size(); i++)
            if (t != s && inr[s].rd != 0 && q[t][i].rd == inr[s].rd) begin
              n_tests++; n_fail++;
              $display("[TB] FAIL stim_hazard: rd %0d queued by src %0d and %0d", inr[s].rd, t, s);
            end
        q[s].push_back(inr[s]);
      end
    end
    #1;
    alu_valid = 1'b0; mul_valid = 1'b0; mem_valid = 1'b0;
    if (rf_we) begin
      writes_seen++;
      wr_log.push_back(rf_waddr);
      $display("[TB] write x%0d <= %08h", rf_waddr, rf_wdata);
    end
    pend = '0;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < q[s].size(); i++) pend[q[s][i].rd] = 1'b1;
    if (m_we) pend[m_waddr] = 1'b1;
    pend[0] = 1'b0;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("alu_ready", alu_ready, q[0].size() < DEPTH);
    chk("mul_ready", mul_ready, q[1].size() < DEPTH);
    chk("mem_ready", mem_ready, q[2].size() < DEPTH);
    chk("pending", pending, pend);
  endtask

  task automatic idle();
    logic [2:0] a;
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, a);
  endtask

  function automatic logic [4:0] rnd_rd(input int s);
    if ($urandom_range(7) == 0) return 5'd0;
    case (s)
      0:       return 5'($urandom_range(10, 1));
      1:       return 5'($urandom_range(20, 11));
      default: return 5'($urandom_range(31, 21));
    endcase
  endfunction

  initial begin
    logic [2:0]  acc;
    logic [4:0]  mq [$];
    logic [4:0]  aq [$];
    logic [4:0]  ra, rm;
    logic [31:0] seq_m, seq_a;
    logic        saw_low, saw_rise;
    int          base, pushed;

    // Directed table: three-way rounds, then a single ALU write.
    vt[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 32'h0, 32'h0000000E};
    vt[1]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  1'b1, 5'd1, 32'h11, 32'h0000000E};
    vt[2]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  1'b1, 5'd2, 32'h22, 32'h0000000C};
    vt[3]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  1'b1, 5'd3, 32'h33, 32'h00000008};
    vt[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h44, 32'h55, 32'h66, 1'b0, 5'd0, 32'h0, 32'h0000000E};
    vt[5]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  1'b1, 5'd1, 32'h44, 32'h0000000E};
    vt[6]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  1'b1, 5'd2, 32'h55, 32'h0000000C};
    vt[7]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  1'b1, 5'd3, 32'h66, 32'h00000008};
    vt[8]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  1'b0, 5'd0, 32'h0, 32'h00000000};
    vt[9]  = '{3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h00000020};
    vt[10] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  1'b1, 5'd5, 32'hDEADBEEF, 32'h00000020};
    vt[11] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0,  32'h0,  1'b0, 5'd0, 32'h0, 32'h00000000};

    reset = 1'b0;
    alu_valid = 1'b0; mul_valid = 1'b0; mem_valid = 1'b0;
    alu_rd = '0; mul_rd = '0; mem_rd = '0;
    alu_data = '0; mul_data = '0; mem_data = '0;
    model_reset();

    #12;
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_waddr", rf_waddr, 5'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_pending", pending, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_readies", {alu_ready, mul_ready, mem_ready}, 3'b111);

    for (int i = 0; i < 12; i++) begin
      step(vt[i].v, vt[i].r0, vt[i].r1, vt[i].r2, vt[i].d0, vt[i].d1, vt[i].d2, acc);
      $display("[TB] vec %0d: we=%0b waddr=%0d pending=%08h", i, rf_we, rf_waddr, pending);
      chk($sformatf("vec%0d_we", i), rf_we, vt[i].we);
      if (vt[i].we) begin
        chk($sformatf("vec%0d_waddr", i), rf_waddr, vt[i].wa);
        chk($sformatf("vec%0d_wdata", i), rf_wdata, vt[i].wd);
      end
      chk($sformatf("vec%0d_pending", i), pending, vt[i].pend);
    end

    // MUL streams rd 7..10 while ALU pushes 20, 21; MUL FIFO must fill.
    mq = '{5'd7, 5'd8, 5'd9, 5'd10};
    aq = '{5'd20, 5'd21};
    base = wr_log.size(); saw_low = 1'b0; saw_rise = 1'b0;
    for (int c = 0; c < 24; c++) begin
      ra = (aq.size() > 0) ? aq[0] : 5'd0;
      rm = (mq.size() > 0) ? mq[0] : 5'd0;
      step({1'b0, mq.size() > 0, aq.size() > 0}, ra, rm, 5'd0,
           32'hA000 + 32'(ra), 32'hB000 + 32'(rm), 32'd0, acc);
      if (acc[0]) void'(aq.pop_front());
      if (acc[1]) void'(mq.pop_front());
      if (!mul_ready) saw_low = 1'b1;
      else if (saw_low) saw_rise = 1'b1;
    end
    seq_m = '0; seq_a = '0;
    for (int i = base; i < wr_log.size(); i++) begin
      if (wr_log[i] >= 7 && wr_log[i] <= 10) seq_m = (seq_m << 8) | 32'(wr_log[i]);
      if (wr_log[i] >= 20) seq_a = (seq_a << 8) | 32'(wr_log[i]);
    end
    chk("mul_alu_write_count", wr_log.size() - base, 6);
    chk("mul_order", seq_m, 32'h0708090A);
    chk("alu_order", seq_a, 32'h00001415);
    chk("mul_ready_dropped", saw_low, 1'b1);
    chk("mul_ready_recovered", saw_rise, 1'b1);

    // rd==0 from MEM: consumed without a write pulse.
    base = writes_seen;
    step(3'b100, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h1234, acc);
    chk("rd0_accepted", acc[2], 1'b1);
    for (int c = 0; c < 3; c++) begin
      idle();
      chk("rd0_pending0", pending[0], 1'b0);
    end
    chk("rd0_no_write", writes_seen - base, 0);
    chk("rd0_mem_ready", mem_ready, 1'b1);

    // ALU alone, 3*DEPTH pushes: pointer wrap, one write per cycle.
    base = writes_seen; pushed = 0;
    for (int c = 0; c < 40; c++) begin
      if (pushed < 3 * DEPTH)
        step(3'b001, 5'(1 + pushed % 9), 5'd0, 5'd0, 32'hC0DE0000 + 32'(pushed), 32'd0, 32'd0, acc);
      else begin
        idle(); acc = 3'b000;
      end
      if (acc[0]) pushed++;
    end
    chk("wrap_pushed", pushed, 3 * DEPTH);
    chk("wrap_writes", writes_seen - base, 3 * DEPTH);

    // Randomized traffic with disjoint rd ranges per source.
    for (int c = 0; c < 300; c++) begin
      step(3'($urandom_range(7)), rnd_rd(0), rnd_rd(1), rnd_rd(2),
           $urandom, $urandom, $urandom, acc);
    end
    for (int c = 0; c < 12; c++) idle();
    chk("random_drained_pending", pending, 32'd0);

    // Reset mid-stream with results buffered in every FIFO.
    for (int c = 0; c < 3; c++)
      step(3'b111, 5'(4 + c), 5'(12 + c), 5'(24 + c), 32'h100 + 32'(c), 32'h200 + 32'(c), 32'h300 + 32'(c), acc);
    reset = 1'b0;
    #1;
    chk("midreset_rf_we", rf_we, 1'b0);
    chk("midreset_pending", pending, 32'd0);
    chk("midreset_readies", {alu_ready, mul_ready, mem_ready}, 3'b111);
    model_reset();
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    base = writes_seen;
    for (int c = 0; c < 4; c++) idle();
    chk("midreset_no_writes", writes_seen - base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
